i2c_byte_writer: RTL

- Downstream stage of the UART receiver in the UART-to-I2C bridge.
- Takes each byte the UART RX delivers over a valid/ready handshake and writes it to a fixed I2C slave as one complete write transaction: START, ADDR+W, ACK, DATA, ACK, STOP.
- Drives open-drain SCL/SDA through output-enable signals and reports completion or NACK back to the top level.

---
 rtl/i2c_byte_writer.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_writer.sv
// i2c_byte_writer: writes each byte received over a valid/ready handshake to a
// fixed 7-bit I2C slave as one transaction: START, ADDR+W, ACK, DATA, ACK, STOP.
// SCL/SDA are open-drain: an *_oe output of 1 pulls the line low, 0 releases it.
//
// Handshake: in_ready is high only while idle. A byte moves on the rising clk
// edge where in_valid and in_ready are both high, and in_data is ignored at all
// other times. The producer may hold in_valid high. The next byte is then taken
// on the first idle cycle after the previous STOP.
//
// Optional build macro: I2C_NACK_RETRY_EN. When it is defined, a NACKed
// transaction is repeated once in full before nack_err is reported.
module i2c_byte_writer #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         I2C_FREQ   = 100000,
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         QTR        = CLK_FREQ / (4 * I2C_FREQ)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    // Quarter-period counter width. QTR must be at least 2.
    localparam int         QW       = $clog2(QTR);
    localparam logic [QW-1:0] QTR_MAX = QW'(QTR - 1);
    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DATA_ACK = 3'd5,
        S_STOP     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            nack_q, nack_d;
    logic            scl_oe_q, scl_oe_d;
    logic            sda_oe_q, sda_oe_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            nack_err_q, nack_err_d;
    logic            sda_s1_q, sda_s2_q;
`ifdef I2C_NACK_RETRY_EN
    logic            retry_q, retry_d;
`endif

    logic tick;
    logic last_q;
    logic accept;

    // One quarter of the SCL period has elapsed. Phases advance on this tick.
    assign tick   = (qcnt_q == QTR_MAX);
    // This is the final tick of a 4-quarter slot (the end of a bit, START or STOP).
    assign last_q = tick && (phase_q == 2'd3);
    assign accept = in_valid && in_ready_q;

    assign in_ready = in_ready_q;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_err_q;

    // Two-flop synchroniser on the SDA input. The released bus idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

    // Next-state logic for the transaction FSM, quarter timing and bit counter.
    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        data_d     = data_q;
        nack_d     = nack_q;
        done_d     = 1'b0;
        nack_err_d = 1'b0;
`ifdef I2C_NACK_RETRY_EN
        retry_d    = retry_q;
`endif

        // The quarter timer runs only while a transaction is active.
        if (state_q != S_IDLE) begin
            qcnt_d = tick ? '0 : qcnt_q + 1'b1;
            if (tick) begin
                phase_d = phase_q + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                qcnt_d  = '0;
                phase_d = 2'd0;
                if (accept) begin
                    data_d  = in_data;
                    nack_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_q) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd7;
                end
            end
            S_ADDR: begin
                if (last_q) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_ADDR_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_ADDR_ACK: begin
                // A released (high) SDA at the sample point means NACK.
                if (last_q) begin
                    if (!sda_s2_q) begin
                        state_d = S_DATA;
                        bit_d   = 3'd7;
                    end else begin
                        state_d = S_STOP;
                        nack_d  = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (last_q) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_DATA_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_DATA_ACK: begin
                if (last_q) begin
                    state_d = S_STOP;
                    if (sda_s2_q) begin
                        nack_d = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (last_q) begin
`ifdef I2C_NACK_RETRY_EN
                    // One full retry of the same byte follows a first NACK.
                    if (nack_q && !retry_q) begin
                        state_d = S_START;
                        retry_d = 1'b1;
                        nack_d  = 1'b0;
                    end else begin
                        state_d    = S_IDLE;
                        retry_d    = 1'b0;
                        done_d     = !nack_q;
                        nack_err_d = nack_q;
                    end
`else
                    state_d    = S_IDLE;
                    done_d     = !nack_q;
                    nack_err_d = nack_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode the line drivers and the status outputs from the next state.
    // Registering them keeps the open-drain enables free of glitches.
    always_comb begin
        scl_oe_d   = 1'b0;
        sda_oe_d   = 1'b0;
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);

        case (state_d)
            S_START: begin
                // SDA falls while SCL is high. SCL is then pulled low for the first bit.
                scl_oe_d = (phase_d == 2'd3);
                sda_oe_d = (phase_d != 2'd0);
            end
            S_ADDR: begin
                scl_oe_d = !phase_d[1];
                sda_oe_d = !ADDR_BYTE[bit_d];
            end
            S_DATA: begin
                scl_oe_d = !phase_d[1];
                sda_oe_d = !data_d[bit_d];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_oe_d = !phase_d[1];
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                // SDA rises while SCL is high.
                scl_oe_d = (phase_d == 2'd0);
                sda_oe_d = (phase_d != 2'd3);
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State register. Reset releases both lines and clears every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            phase_q    <= 2'd0;
            bit_q      <= 3'd0;
            data_q     <= 8'd0;
            nack_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            nack_q     <= nack_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_err_q <= nack_err_d;
`ifdef I2C_NACK_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

endmodule
